counter_cell_scheduler: RTL and testbench
=========================================

Name: counter_cell_scheduler

Overview:
- Parametrised successor to the fixed counter-cell / counter-priority logic (Cxx request cells, CAD1..CAD6 address, PINC/MINC, CTROR).
- Latches up/down increment requests from NCHAN involuntary counters and arbitrates them by fixed priority.
- Presents one counter address and increment type per memory-cycle handshake to the counter-sequence logic.
- Adds three behaviours the fixed block lacks: configurable channel count and address base, plus/minus cancellation, and an inhibit input.

Parameters:
- NCHAN, 32, number of counter channels (1..64).
- ADDRW, 6, counter address width.
- BASE_ADDR, 6'o24, erasable address of channel 0; channel i maps to BASE_ADDR+i.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_plus  input  NCHAN  per-channel single-cycle plus-increment request pulses
- req_minus  input  NCHAN  per-channel single-cycle minus-increment request pulses
- inhibit  input  1  blocks new grants (MNHNC-style); does not drop latched requests
- serv_ack  input  1  counter sequencer accepted the presented request
- serv_done  input  1  counter update cycle complete
- ovf_in  input  1  serviced counter overflowed; sampled with serv_done; used only with CHAIN_OVF_EN
- serv_req  output  1  request pending toward counter sequencer (CTROR)
- cad  output  ADDRW  counter address, BASE_ADDR + granted channel
- cinc_plus  output  1  granted operation is +1 (PINC)
- cinc_minus  output  1  granted operation is -1 (MINC)
- pend  output  NCHAN  latched request cells, for monitor/debug
- busy  output  1  high in REQ and SERV states

Behaviour:
- Reset: all pending cells 0; state IDLE. serv_req, cinc_plus, cinc_minus, busy = 0; cad = BASE_ADDR; pend = 0. Takes effect in the clock after rst is sampled high, including mid-operation. No pending cells are retained.
- Cell update, per channel each clock:
  - pend_p sets on req_plus; pend_m sets on req_minus.
  - Plus and minus both set, or both arriving, or one arriving while the other is latched: both cells clear (net zero).
  - Cells of the channel being serviced clear on serv_done. A new request in the same cycle as serv_done wins: the cell is left set.
- pend[i] = pend_p[i] | pend_m[i].
- Priority: lowest index with pend set wins. The winner is frozen at the IDLE->REQ transition and does not change until return to IDLE.
- States and transitions:
  - IDLE: if any pend and !inhibit -> REQ. Capture channel and type; latch cad.
  - REQ: serv_req=1, cad and cinc_* valid and stable. On serv_ack -> SERV.
  - SERV: serv_req=0; cad and cinc_* held. On serv_done -> IDLE and clear that channel's cells.
- Cancellation while in REQ or SERV: if the granted channel is cancelled by an opposite request, the transaction still completes with the captured type. The cells end cleared.
- ack and done in the same cycle while in REQ: go straight to IDLE.
- Latency:
  - Pulse at cycle t -> pend visible at t+1 -> serv_req high at t+2 (if IDLE and not inhibited).
  - A back-to-back grant follows one IDLE cycle after done.
- inhibit is sampled only in IDLE; a transaction already in REQ or SERV completes.
- Exactly one of cinc_plus / cinc_minus is high when busy; both are low otherwise.
- cad arithmetic: modulo 2^ADDRW; no range check.

Optional Feature:
- Macro: CHAIN_OVF_EN.
- Defined: ovf_in=1 with serv_done on channel k < NCHAN-1 sets pend_p[k+1] in the same clock as the clear of channel k. This gives TIME1->TIME2-style chaining. If channel k+1 also receives req_minus that cycle, the normal cancellation applies. Overflow on channel NCHAN-1 is discarded.
- Not defined: ovf_in is ignored and no chaining logic is synthesised.

Test Plan:
- Single request: req_plus[3] pulse at t, NCHAN=32 -> serv_req=1 at t+2, cad=6'o27, cinc_plus=1. After ack then done, pend[3]=0 and state IDLE.
- Priority: req_minus[10] and req_plus[2] in the same cycle -> first grant cad=6'o26 plus, second grant cad=6'o36 minus.
- Cancellation: req_plus[5] at t, req_minus[5] at t+1 while inhibit=1 -> pend[5]=0 at t+2; with inhibit released, no serv_req.
- Done collision: req_plus[4] arrives in the same cycle as serv_done for channel 4 -> pend[4] remains 1 and channel 4 is granted again after one IDLE cycle.
- Reset mid-SERV: rst during SERV with pend=0x0000_0011 -> next cycle pend=0, serv_req=0, busy=0, cad=6'o24.
- CHAIN_OVF_EN: channel 0 serviced with ovf_in=1 at done -> pend[1]=1 next cycle and channel 1 is granted as plus. Without the macro, pend[1] stays 0.

Source files
------------

// File: rtl/counter_cell_scheduler.sv
// Counter-cell request latching and fixed-priority scheduler for involuntary counters.
// Optional macro CHAIN_OVF_EN: an overflow on channel k chains a plus request into k+1.
module counter_cell_scheduler #(
  parameter int               NCHAN     = 32,
  parameter int               ADDRW     = 6,
  parameter logic [ADDRW-1:0] BASE_ADDR = ADDRW'(6'o24)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCHAN-1:0] req_plus,
  input  logic [NCHAN-1:0] req_minus,
  input  logic             inhibit,
  input  logic             serv_ack,
  input  logic             serv_done,
  input  logic             ovf_in,
  output logic             serv_req,
  output logic [ADDRW-1:0] cad,
  output logic             cinc_plus,
  output logic             cinc_minus,
  output logic [NCHAN-1:0] pend,
  output logic             busy
);

  localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  logic [1:0]       state;
  logic [CHW-1:0]   gch;
  logic             gplus;
  logic [NCHAN-1:0] pend_p, pend_m, clr, chain_set;
  logic [CHW-1:0]   win;
  logic             win_plus;
  logic             done_fire;

  assign pend = pend_p | pend_m;

  // Done only counts once the sequencer has accepted the request (ack may coincide).
  assign done_fire = ((state == S_SERV) && serv_done) ||
                     ((state == S_REQ) && serv_ack && serv_done);

  always_comb begin
    win      = '0;
    win_plus = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win      = CHW'(i);
        win_plus = pend_p[i];
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NCHAN; i++)
      clr[i] = done_fire && (gch == CHW'(i));
  end

`ifdef CHAIN_OVF_EN
  always_comb begin
    chain_set = '0;
    for (int i = 1; i < NCHAN; i++)
      chain_set[i] = done_fire && ovf_in && (gch == CHW'(i - 1));
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_in;
  assign chain_set  = '0;
`endif

  for (genvar g = 0; g < NCHAN; g++) begin : g_cell
    logic p_q, m_q, np, nm;
    // Clear happens before set so a request coinciding with done survives.
    always_comb begin
      np = (p_q & ~clr[g]) | req_plus[g] | chain_set[g];
      nm = (m_q & ~clr[g]) | req_minus[g];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        p_q <= 1'b0;
        m_q <= 1'b0;
      end else begin
        p_q <= np & ~nm;
        m_q <= nm & ~np;
      end
    end
    assign pend_p[g] = p_q;
    assign pend_m[g] = m_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gch   <= '0;
      gplus <= 1'b0;
      cad   <= BASE_ADDR;
    end else begin
      case (state)
        S_IDLE: if (|pend && !inhibit) begin
          state <= S_REQ;
          gch   <= win;
          gplus <= win_plus;
          cad   <= BASE_ADDR + ADDRW'(win);
        end
        S_REQ:  if (serv_ack) state <= serv_done ? S_IDLE : S_SERV;
        S_SERV: if (serv_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign serv_req   = (state == S_REQ);
  assign busy       = (state == S_REQ) || (state == S_SERV);
  assign cinc_plus  = busy & gplus;
  assign cinc_minus = busy & ~gplus;

endmodule

// File: tb/tb_counter_cell_scheduler.sv
// Bench for counter_cell_scheduler: directed steps plus random traffic vs a transaction-level model.
module tb_counter_cell_scheduler;
  localparam int N  = 32;
  localparam int AW = 6;
  localparam logic [AW-1:0] BASE = 6'o24;

  logic          clk = 1'b0;
  logic          rst, inhibit, serv_ack, serv_done, ovf_in;
  logic [N-1:0]  req_plus, req_minus, pend;
  logic          serv_req, cinc_plus, cinc_minus, busy;
  logic [AW-1:0] cad;

  counter_cell_scheduler #(.NCHAN(N), .ADDRW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_plus(req_plus), .req_minus(req_minus),
    .inhibit(inhibit), .serv_ack(serv_ack), .serv_done(serv_done), .ovf_in(ovf_in),
    .serv_req(serv_req), .cad(cad), .cinc_plus(cinc_plus), .cinc_minus(cinc_minus),
    .pend(pend), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: latched plus/minus sets, plus the current transaction (granted, accepted, channel, type).
  logic [N-1:0]  mp = '0, mm = '0;
  bit            granted = 0, acked = 0, gplus = 0;
  int            gch = 0;
  logic [AW-1:0] mcad = BASE;

  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("pend",       64'(pend),       64'(mp | mm));
    chk("serv_req",   64'(serv_req),   64'(granted && !acked));
    chk("busy",       64'(busy),       64'(granted));
    chk("cad",        64'(cad),        64'(mcad));
    chk("cinc_plus",  64'(cinc_plus),  64'(granted && gplus));
    chk("cinc_minus", 64'(cinc_minus), 64'(granted && !gplus));
  endtask

  task automatic cyc(input logic [N-1:0] rp, input logic [N-1:0] rm, input logic inh_v,
                     input logic ack_v, input logic done_v, input logic ovf_v, input logic rst_v);
    logic [N-1:0]  np, nm;
    bit            ng, na, ngp, fire;
    int            ngch, lo;
    logic [AW-1:0] ncad;
    bit            lp, lm, sp, sm;
    req_plus = rp; req_minus = rm; inhibit = inh_v;
    serv_ack = ack_v; serv_done = done_v; ovf_in = ovf_v; rst = rst_v;
    np = '0; nm = '0; ng = 0; na = 0; ngp = gplus; ngch = gch; ncad = BASE;
    if (!rst_v) begin
      fire = granted && (acked ? done_v : (ack_v && done_v));
      for (int i = 0; i < N; i++) begin
        lp = mp[i] && !(fire && gch == i);
        lm = mm[i] && !(fire && gch == i);
        sp = rp[i];
`ifdef CHAIN_OVF_EN
        if (fire && ovf_v && i == gch + 1) sp = 1;
`endif
        sm = rm[i];
        // Net-zero: any plus meeting any minus leaves the channel empty.
        if ((lp || sp) && (lm || sm)) begin np[i] = 0; nm[i] = 0; end
        else begin np[i] = lp || sp; nm[i] = lm || sm; end
      end
      ng = granted; na = acked; ncad = mcad;
      if (!granted) begin
        if ((mp | mm) != '0 && !inh_v) begin
          lo = 0;
          for (int i = N - 1; i >= 0; i--) if (mp[i] || mm[i]) lo = i;
          ng = 1; na = 0; ngch = lo; ngp = mp[lo];
          ncad = AW'((int'(BASE) + lo) % (1 << AW));
        end
      end else if (!acked) begin
        if (ack_v) begin
          if (done_v) ng = 0; else na = 1;
        end
      end else if (done_v) begin
        ng = 0; na = 0;
      end
    end
    @(posedge clk);
    mp = np; mm = nm; granted = ng; acked = na; gch = ngch; gplus = ngp; mcad = ncad;
    #1;
    check_all();
  endtask

  function automatic logic [N-1:0] bitn(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] rp, rm;
    req_plus = '0; req_minus = '0; inhibit = 0; serv_ack = 0; serv_done = 0; ovf_in = 0; rst = 1;

    cyc('0, '0, 0, 0, 0, 0, 1);
    cyc('0, '0, 0, 0, 0, 0, 1);
    chk("reset_cad", 64'(cad), 64'(6'o24));
    chk("reset_busy", 64'(busy), 64'd0);

    // Single plus on channel 3.
    cyc(bitn(3), '0, 0, 0, 0, 0, 0);
    chk("single_pend", 64'(pend), 64'h8);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("single_req", 64'(serv_req), 64'd1);
    chk("single_cad", 64'(cad), 64'(6'o27));
    chk("single_plus", 64'(cinc_plus), 64'd1);
    cyc('0, '0, 0, 1, 0, 0, 0);
    cyc('0, '0, 0, 0, 1, 0, 0);
    chk("single_clear", 64'(pend), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Priority: channel 2 plus beats channel 10 minus.
    cyc(bitn(2), bitn(10), 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("prio1_cad", 64'(cad), 64'(6'o26));
    chk("prio1_plus", 64'(cinc_plus), 64'd1);
    cyc('0, '0, 0, 1, 1, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("prio2_cad", 64'(cad), 64'(6'o36));
    chk("prio2_minus", 64'(cinc_minus), 64'd1);
    cyc('0, '0, 0, 1, 0, 0, 0);
    cyc('0, '0, 0, 0, 1, 0, 0);

    // Cancellation under inhibit.
    cyc(bitn(5), '0, 1, 0, 0, 0, 0);
    cyc('0, bitn(5), 1, 0, 0, 0, 0);
    chk("cancel_pend", 64'(pend[5]), 64'd0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("cancel_noreq", 64'(serv_req), 64'd0);

    // New request collides with done on the same channel.
    cyc(bitn(4), '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 1, 0, 0, 0);
    cyc(bitn(4), '0, 0, 0, 1, 0, 0);
    chk("collide_pend", 64'(pend[4]), 64'd1);
    chk("collide_idle", 64'(busy), 64'd0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("collide_regrant", 64'(cad), 64'(6'o30));
    cyc('0, '0, 0, 1, 1, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);

    // Reset during SERV.
    cyc(32'h11, '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 1, 0, 0, 0);
    chk("rst_pre_pend", 64'(pend), 64'h11);
    cyc('0, '0, 0, 0, 0, 0, 1);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_req", 64'(serv_req), 64'd0);
    chk("rst_cad", 64'(cad), 64'(6'o24));
    cyc('0, '0, 0, 0, 0, 0, 0);

    // Overflow chaining from channel 0 to channel 1.
    cyc(bitn(0), '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 0, 0, 0, 0);
    cyc('0, '0, 0, 1, 0, 0, 0);
    cyc('0, '0, 0, 0, 1, 1, 0);
`ifdef CHAIN_OVF_EN
    chk("chain_pend", 64'(pend[1]), 64'd1);
    cyc('0, '0, 0, 0, 0, 0, 0);
    chk("chain_cad", 64'(cad), 64'(6'o25));
    chk("chain_plus", 64'(cinc_plus), 64'd1);
    cyc('0, '0, 0, 1, 1, 0, 0);
`else
    chk("nochain_pend", 64'(pend[1]), 64'd0);
`endif
    cyc('0, '0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      rp = $urandom & $urandom & $urandom & $urandom;
      rm = $urandom & $urandom & $urandom & $urandom;
      cyc(rp, rm, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
          $urandom_range(0, 1), ($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
